alu_muldiv: RTL and testbench

Multi-cycle RV32M multiply/divide responder. It sits beside the single-cycle combinational alu in the execute stage. The core is the initiator: it presents an operator and two operands with a valid/ready handshake, and this block returns one 32-bit result per accepted request. Iterative radix-2 datapath, one result bit per cycle; the core stalls on req_ready/resp_valid.

---
 rtl/alu_muldiv.sv | 79 +++++++
 tb/tb_alu_muldiv.sv | 106 ++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M mul/div responder; req_valid/req_ready/operator/operand1/operand2 in, resp_valid/resp_ready/out/busy handshake out
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_WIDTH-1:0] operator,
  input  logic [XLEN-1:0]     operand1,
  input  logic [XLEN-1:0]     operand2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     out,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [OP_WIDTH-1:0] op;
  logic [$clog2(XLEN)-1:0] cnt;
  logic s1, s2, a_s1, a_s2, accept, div0, ovf, special, ge;
  logic [XLEN-1:0] b, mag1, mag2, spec_res, res;
  logic [2*XLEN-1:0] prod, prod_nxt, mul_res;
  logic [XLEN:0] sum, t, diff;
  always_comb begin
    accept = req_valid && state == IDLE;
    a_s1 = operand1[XLEN-1] & ~(operator[0] & (operator[1] | operator[2]));
    a_s2 = operand2[XLEN-1] & ~(operator[2] ? operator[0] : operator[1]);
    mag1 = a_s1 ? -operand1 : operand1;
    mag2 = a_s2 ? -operand2 : operand2;
    div0 = operand2 == '0;
    ovf = ~operator[0] && operand1 == {1'b1, {(XLEN-1){1'b0}}} && &operand2;
    special = operator[2] && (div0 || ovf);
    spec_res = div0 ? (operator[1] ? operand1 : '1) : (operator[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, prod[0] ? b : {XLEN{1'b0}}};
    t = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    diff = t - {1'b0, b};
    ge = t >= {1'b0, b};
    prod_nxt = op[2] ? {(ge ? diff[XLEN-1:0] : t[XLEN-1:0]), prod[XLEN-2:0], ge} : {sum, prod[XLEN-1:1]};
    mul_res = (s1 ^ s2) ? -prod_nxt : prod_nxt;
    res = ~op[2] ? (op[1:0] == 2'd0 ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN])
        : op[1] ? (s1 ? -prod_nxt[2*XLEN-1:XLEN] : prod_nxt[2*XLEN-1:XLEN])
        : ((s1 ^ s2) ? -prod_nxt[XLEN-1:0] : prod_nxt[XLEN-1:0]);
    state_nxt = state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE)
              : state == CALC ? (cnt == ($clog2(XLEN))'(XLEN-1) ? DONE : CALC)
              : (resp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out <= '0;
      op <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      b <= '0;
      prod <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op <= operator;
        s1 <= a_s1;
        s2 <= a_s2;
        cnt <= '0;
        b <= operator[2] ? mag2 : mag1;
        prod <= {{XLEN{1'b0}}, operator[2] ? mag1 : mag2};
        if (special) out <= spec_res;
      end else if (state == CALC) begin
        prod <= prod_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == ($clog2(XLEN))'(XLEN-1)) out <= res;
      end
    end
  end
  assign req_ready = state == IDLE;
  assign resp_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed scoreboard bench for alu_muldiv
module tb_alu_muldiv;
  logic clk = 0, rst = 1, req_valid = 0, resp_ready = 1;
  logic req_ready, resp_valid, busy;
  logic [2:0] operator = 0;
  logic [31:0] operand1 = 0, operand2 = 0, out;
  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  typedef struct {logic [2:0] op; logic [31:0] a, b, e; int lat; int hold; string name;} vec_t;
  vec_t vecs[$];
  alu_muldiv #(.XLEN(32), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .operator(operator), .operand1(operand1), .operand2(operand2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .out(out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h expected no response", out);
      end else chk({name_q.pop_front(), "_out"}, out, exp_q.pop_front());
    end
  end
  task automatic run(input vec_t v);
    int n;
    logic [31:0] held;
    @(posedge clk); #1;
    resp_ready = v.hold == 0;
    operator = v.op; operand1 = v.a; operand2 = v.b; req_valid = 1;
    exp_q.push_back(v.e); name_q.push_back(v.name);
    @(posedge clk); #1;
    req_valid = 0; operand1 = $urandom; operand2 = $urandom; operator = 3'($urandom);
    chk({v.name, "_req_ready_low"}, 32'(req_ready), 0);
    n = 0;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({v.name, "_latency"}, n + 1, v.lat);
    if (v.hold > 0) begin
      held = out;
      repeat (v.hold) begin
        @(posedge clk); #1;
        chk({v.name, "_hold_out"}, out, held);
        chk({v.name, "_hold_flags"}, {30'd0, resp_valid, req_ready}, 32'd2);
      end
      resp_ready = 1;
      @(posedge clk); #1;
      chk({v.name, "_release"}, {30'd0, resp_valid, req_ready}, 32'd1);
    end else begin
      n = 0;
      while (resp_valid && n < 5) begin @(posedge clk); #1; n++; end
      chk({v.name, "_consumed"}, 32'(resp_valid), 0);
    end
  endtask
  initial begin
    logic seen;
    vecs.push_back('{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "mul"});
    vecs.push_back('{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 33, 0, "mulh"});
    vecs.push_back('{3'd2, 32'h80000000,   32'h80000000, 32'hC0000000, 33, 0, "mulhsu"});
    vecs.push_back('{3'd3, 32'h80000000,   32'h80000000, 32'h40000000, 33, 0, "mulhu"});
    vecs.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "mulhu_max"});
    vecs.push_back('{3'd0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33, 0, "mul_minneg"});
    vecs.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33, 0, "div_neg"});
    vecs.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33, 0, "rem_neg"});
    vecs.push_back('{3'd5, 32'd100,        32'd7,        32'd14,       33, 0, "divu"});
    vecs.push_back('{3'd7, 32'd100,        32'd7,        32'd2,        33, 0, "remu"});
    vecs.push_back('{3'd4, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0, "div_negdivisor"});
    vecs.push_back('{3'd6, 32'd7,          32'hFFFFFFFE, 32'd1,        33, 0, "rem_negdivisor"});
    vecs.push_back('{3'd7, 32'hFFFFFFFF,   32'h10,       32'hF,        33, 0, "remu_max"});
    vecs.push_back('{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 1,  0, "div_by0"});
    vecs.push_back('{3'd7, 32'd5,          32'd0,        32'd5,        1,  0, "remu_by0"});
    vecs.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1,  0, "div_ovf"});
    vecs.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1,  0, "rem_ovf"});
    vecs.push_back('{3'd5, 32'd100,        32'd7,        32'd14,       33, 10, "backpressure"});
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_flags", {28'd0, req_ready, resp_valid, busy, 1'b0}, 32'h8);
    chk("reset_out", out, 0);
    foreach (vecs[i]) run(vecs[i]);
    @(posedge clk); #1;
    operator = 3'd5; operand1 = 32'd100; operand2 = 32'd7; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (14) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("midreset_flags", {28'd0, req_ready, resp_valid, busy, 1'b0}, 32'h8);
    chk("midreset_out", out, 0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= resp_valid; end
    chk("midreset_no_resp", 32'(seen), 0);
    run('{3'd5, 32'd9, 32'd3, 32'd3, 33, 0, "divu_after_reset"});
    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
